// File: rtl/t1_sim_watchdog_if.sv
// Bus bundle for t1_sim_watchdog: run-control inputs and watchdog status outputs.
// master drives the controls and observes status; slave is the watchdog itself.
interface t1_sim_watchdog_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CYC_W  = 64
);
  logic [NUM_CH-1:0] retire;
  logic [NUM_CH-1:0] ch_done;
  logic [CNT_W-1:0]  timeout;
  logic [CYC_W-1:0]  global_timeout;
  logic [CYC_W-1:0]  dump_start;
  logic [CYC_W-1:0]  dump_end;
  logic [7:0]        status;
  logic [3:0]        fail_ch;
  logic [CYC_W-1:0]  cycle;
  logic              finish;
  logic              dump_en;

  modport master (
    output retire, ch_done, timeout, global_timeout, dump_start, dump_end,
    input  status, fail_ch, cycle, finish, dump_en
  );

  modport slave (
    input  retire, ch_done, timeout, global_timeout, dump_start, dump_end,
    output status, fail_ch, cycle, finish, dump_en
  );
endinterface

// File: rtl/t1_sim_watchdog.sv
// Simulation watchdog: per-channel idle timeouts, whole-run cycle limit, drain-then-pass
// sequencing and an optional wave-dump window.
// Optional feature macro: T1_WATCHDOG_DUMP_EN enables the dump_en window logic; when it is
// undefined dump_en is tied low and dump_start/dump_end are ignored.
module t1_sim_watchdog #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CYC_W     = 64,
  parameter int unsigned DRAIN_CYC = 8
) (
  input logic            clock,
  input logic            reset,
  t1_sim_watchdog_if.slave bus
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StPass  = 2'd2;
  localparam logic [1:0] StFail  = 2'd3;

  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [7:0]        status_q, status_d;
  logic [3:0]        fail_ch_q, fail_ch_d;
  logic              finish_q, finish_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [NUM_CH-1:0] done_q, done_now, hit;
  logic [CNT_W-1:0]  idle_q [NUM_CH];
  logic [CNT_W-1:0]  idle_d [NUM_CH];
  logic [CNT_W-1:0]  limit;
  logic [3:0]        first_hit;
  logic              ch_fail, glob_fail, all_done;

  assign cycle_d = cycle_q + CYC_W'(1);
  assign limit   = bus.timeout - CNT_W'(1);

  // Per-channel idle counters, sticky done and timeout detection (lowest index wins).
  always_comb begin
    done_now  = done_q | bus.ch_done;
    hit       = '0;
    first_hit = '0;
    idle_d    = idle_q;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = ~done_now[i] & ~bus.retire[i] & (bus.timeout != '0) & (idle_q[i] == limit);
      if (bus.retire[i] || done_now[i]) begin
        idle_d[i] = '0;
      end else if (idle_q[i] != '1) begin
        idle_d[i] = idle_q[i] + CNT_W'(1);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (hit[i]) first_hit = 4'(i);
    end
  end

  assign ch_fail   = |hit;
  assign glob_fail = (bus.global_timeout != '0) && (cycle_d == bus.global_timeout);
  assign all_done  = &done_now;

  // Run-state sequencing; a channel timeout outranks a coincident global timeout.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    fail_ch_d = fail_ch_q;
    drain_d   = drain_q;
    case (state_q)
      StRun: begin
        if (ch_fail) begin
          state_d   = StFail;
          status_d  = 8'd1;
          fail_ch_d = first_hit;
        end else if (glob_fail) begin
          state_d  = StFail;
          status_d = 8'd2;
        end else if (all_done) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        if (glob_fail) begin
          state_d  = StFail;
          status_d = 8'd2;
        end else if (drain_q == DrainLast) begin
          state_d  = StPass;
          status_d = 8'd255;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      default: ;
    endcase
    finish_d = ((state_q == StRun) || (state_q == StDrain)) &&
               ((state_d == StPass) || (state_d == StFail));
  end

  // Core state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StRun;
      cycle_q   <= '0;
      status_q  <= '0;
      fail_ch_q <= '0;
      finish_q  <= 1'b0;
      drain_q   <= '0;
      done_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) idle_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      status_q  <= status_d;
      fail_ch_q <= fail_ch_d;
      finish_q  <= finish_d;
      drain_q   <= drain_d;
      done_q    <= done_now;
      idle_q    <= idle_d;
    end
  end

`ifdef T1_WATCHDOG_DUMP_EN
  logic dump_en_q, dump_en_d;

  // Dump window: open at dump_start (or right after reset when 0), close at dump_end or end.
  always_comb begin
    dump_en_d = dump_en_q;
    if ((cycle_d == bus.dump_start) || ((bus.dump_start == '0) && (cycle_q == '0))) begin
      dump_en_d = 1'b1;
    end
    if ((bus.dump_end != '0) && (cycle_d == bus.dump_end)) dump_en_d = 1'b0;
    if ((state_d == StPass) || (state_d == StFail)) dump_en_d = 1'b0;
  end

  // Dump window register.
  always_ff @(posedge clock) begin
    if (!reset) dump_en_q <= 1'b0;
    else        dump_en_q <= dump_en_d;
  end

  assign bus.dump_en = dump_en_q;
`else
  logic unused_dump;
  assign unused_dump = ^{bus.dump_start, bus.dump_end};
  assign bus.dump_en = 1'b0;
`endif

  assign bus.status  = status_q;
  assign bus.fail_ch = fail_ch_q;
  assign bus.cycle   = cycle_q;
  assign bus.finish  = finish_q;

endmodule

// File: doc/t1_sim_watchdog.md
T1_SIM_WATCHDOG -- requirements
Module: t1_sim_watchdog

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored retire channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, width of per-channel idle counters and timeout limit.
REQ-003 SHALL have parameter CYC_W, default 64, width of the free-running cycle counter and global/dump cycle inputs.
REQ-004 SHALL have parameter DRAIN_CYC, default 8, cycles held in DRAIN before PASS.
REQ-005 SHALL use one clock; reset is synchronous and active-low. Ports: clock, reset.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low; low at a rising edge resets all state.
REQ-008 retire  input  NUM_CH  per-channel retire pulse, one bit per channel.
REQ-009 ch_done  input  NUM_CH  per-channel completion level; sampled every cycle, need not persist.
REQ-010 timeout  input  CNT_W  per-channel idle limit in cycles; 0 disables channel timeout.
REQ-011 global_timeout  input  CYC_W  whole-run cycle limit; 0 disables.
REQ-012 dump_start  input  CYC_W  cycle at which wave dump window opens.
REQ-013 dump_end  input  CYC_W  cycle at which dump window closes; 0 means never.
REQ-014 status  output  8  0 running, 255 pass, 1 channel timeout, 2 global timeout.
REQ-015 fail_ch  output  4  lowest-index channel that timed out; valid when status==1.
REQ-016 cycle  output  CYC_W  cycles completed since reset release.
REQ-017 finish  output  1  single-cycle pulse on entry to PASS or FAIL.
REQ-018 dump_en  output  1  high while wave dump window is open.

Function
REQ-019 SHALL increment cycle by 1 every non-reset clock edge, wrapping modulo 2^CYC_W, and SHALL keep counting in PASS and FAIL.
REQ-020 SHALL implement FSM states RUN, DRAIN, PASS, FAIL; RUN after reset.
REQ-021 Per channel: idle counter clears on retire bit high or in sticky done; otherwise increments, saturating at all-ones.
REQ-022 Each channel SHALL latch a sticky done flag on ch_done high; sticky flags clear only on reset.
REQ-023 RUN->FAIL(status 1) on the edge where any not-done channel's idle counter equals timeout-1 with no retire that cycle and timeout!=0; fail_ch = lowest such index.
REQ-024 RUN or DRAIN->FAIL(status 2) on the edge where cycle+1 == global_timeout and global_timeout!=0.
REQ-025 Channel timeout and global timeout in the same cycle SHALL report status 1.
REQ-026 RUN->DRAIN when all sticky done flags (including ones setting this cycle) are set and no failure is detected that cycle.
REQ-027 DRAIN SHALL last exactly DRAIN_CYC cycles, then ->PASS(status 255); channel timeouts are ignored in DRAIN.
REQ-028 PASS and FAIL SHALL be terminal until reset; status and fail_ch hold.
REQ-029 finish SHALL pulse high for exactly one cycle, the first cycle status is 255 or nonzero failure.
REQ-030 Latency: status changes on the clock edge following the triggering input cycle (1 cycle).

Reset
REQ-031 While reset is low at an edge: state RUN, cycle 0, status 0, fail_ch 0, finish 0, dump_en 0, idle counters 0, done flags 0.
REQ-032 Reset asserted mid-run, in DRAIN, PASS or FAIL SHALL return all state to REQ-031 values at that edge, no finish pulse.

Configuration
REQ-033 Macro T1_WATCHDOG_DUMP_EN: when defined, dump_en rises the edge cycle becomes dump_start (immediately after reset if dump_start==0) and falls the edge cycle becomes dump_end (dump_end!=0); also falls on entry to PASS/FAIL.
REQ-034 When T1_WATCHDOG_DUMP_EN is undefined, dump_en SHALL be constant 0 and no dump comparators SHALL exist; dump_start/dump_end ignored.

Verification
REQ-035 NUM_CH=4, timeout=10, retire all channels every 3 cycles, ch_done all at cycle 50 -> DRAIN cycles 51-58, status 255 at cycle 59, finish one pulse.
REQ-036 timeout=10, channel 2 never retires, others retire each cycle -> status 1, fail_ch 2, at cycle 10; finish pulse.
REQ-037 global_timeout=100, timeout=0, no ch_done -> status 2 at cycle 100; timeout=50 and global_timeout=50 with channel 1 idle -> status 1, fail_ch 1.
REQ-038 Channel 0 done at cycle 5 then idle 1000 cycles, others retire -> no timeout on channel 0.
REQ-039 Reset pulled low at cycle 30 mid-DRAIN -> next cycle all outputs 0, cycle restarts at 0, RUN.
REQ-040 With T1_WATCHDOG_DUMP_EN, dump_start=20, dump_end=40 -> dump_en high cycles 20-39; without macro dump_en stays 0.
